// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle LEGv8 core: sequences ALU, memory port and datapath register enables.
// Debug encoding on o_state: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 RTYPE_EX=6 RTYPE_WB=7 CBZ=8 BR=9 ILLEGAL=10.
module multicycle_ctrl #(
  parameter int OPW = 11
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [OPW-1:0] i_op,
  input  logic           i_zero,
  input  logic           i_mem_ready,
  output logic           o_mem_read,
  output logic           o_mem_write,
  output logic           o_iord,
  output logic           o_ir_we,
  output logic           o_pc_we,
  output logic           o_reg_we,
  output logic [1:0]     o_alusrca,
  output logic [1:0]     o_alusrcb,
  output logic [3:0]     o_alucontrol,
  output logic           o_pcsrc,
  output logic           o_mem_to_reg,
  output logic           o_reg2loc,
  output logic           o_illegal,
  output logic [3:0]     o_state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    CBZ      = 4'd8,
    BR       = 4'd9,
    ILLEGAL  = 4'd10
  } state_t;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  state_t     r_state;
  state_t     w_next;
  logic       w_isLdur;
  logic       w_isStur;
  logic       w_isRtype;
  logic       w_isCbz;
  logic       w_isB;
  logic [3:0] w_rAlu;

  always_comb begin
    w_isLdur  = (i_op == 11'b11111000010);
    w_isStur  = (i_op == 11'b11111000000);
    w_isCbz   = (i_op[OPW-1 -: 8] == 8'b10110100);
    w_isB     = (i_op[OPW-1 -: 6] == 6'b000101);
    w_isRtype = 1'b1;
    w_rAlu    = ALU_ADD;
    case (i_op)
      11'b10001011000: w_rAlu = ALU_ADD;
      11'b11001011000: w_rAlu = ALU_SUB;
      11'b10001010000: w_rAlu = ALU_AND;
      11'b10101010000: w_rAlu = ALU_ORR;
      default:         w_isRtype = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = FETCH;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_iord       = 1'b0;
    o_ir_we      = 1'b0;
    o_pc_we      = 1'b0;
    o_reg_we     = 1'b0;
    o_alusrca    = 2'b00;
    o_alusrcb    = 2'b00;
    o_alucontrol = ALU_AND;
    o_pcsrc      = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg2loc    = 1'b0;
    o_illegal    = 1'b0;
    case (r_state)
      FETCH: begin
        o_mem_read   = 1'b1;
        o_alusrcb    = 2'b01;
        o_alucontrol = ALU_ADD;
        if (i_mem_ready) begin
          o_ir_we = 1'b1;
          o_pc_we = 1'b1;
          w_next  = DECODE;
        end else begin
          w_next  = FETCH;
        end
      end
      DECODE: begin
        // ALUOut captures the branch target here so CBZ/B can load it later
        o_alusrca    = 2'b01;
        o_alusrcb    = 2'b11;
        o_alucontrol = ALU_ADD;
        o_reg2loc    = w_isStur | w_isCbz;
        if (w_isLdur || w_isStur) w_next = MEMADR;
        else if (w_isRtype)       w_next = RTYPE_EX;
        else if (w_isCbz)         w_next = CBZ;
        else if (w_isB)           w_next = BR;
        else                      w_next = ILLEGAL;
      end
      MEMADR: begin
        o_alusrca    = 2'b10;
        o_alusrcb    = 2'b10;
        o_alucontrol = ALU_ADD;
        o_reg2loc    = w_isStur;
        w_next       = w_isLdur ? MEMRD : MEMWR;
      end
      MEMRD: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
        w_next     = i_mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        o_reg_we     = 1'b1;
        o_mem_to_reg = 1'b1;
        w_next       = FETCH;
      end
      MEMWR: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
        o_reg2loc   = 1'b1;
        w_next      = i_mem_ready ? FETCH : MEMWR;
      end
      RTYPE_EX: begin
        o_alusrca    = 2'b10;
        o_alusrcb    = 2'b00;
        o_alucontrol = w_rAlu;
        w_next       = RTYPE_WB;
      end
      RTYPE_WB: begin
        o_reg_we = 1'b1;
        w_next   = FETCH;
      end
      CBZ: begin
        o_reg2loc    = 1'b1;
        o_alusrcb    = 2'b00;
        o_alucontrol = ALU_PASSB;
        o_pcsrc      = 1'b1;
        o_pc_we      = i_zero;
        w_next       = FETCH;
      end
      BR: begin
        o_pc_we = 1'b1;
        o_pcsrc = 1'b1;
        w_next  = FETCH;
      end
      ILLEGAL: begin
        o_illegal = 1'b1;
        w_next    = FETCH;
      end
      default: w_next = FETCH;
    endcase
    // FETCH decode alone would raise ir_we/pc_we on mem_ready while reset is held
    if (!i_rst_n) begin
      o_ir_we  = 1'b0;
      o_pc_we  = 1'b0;
      o_reg_we = 1'b0;
    end
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a randomized
// instruction stream checked against per-instruction cycle/pulse counts.
module tb_multicycle_ctrl;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_REX = 4'd6, S_RWB = 4'd7;
  localparam logic [3:0] S_CBZ = 4'd8, S_BR = 4'd9, S_ILL = 4'd10;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010100000;

  localparam int K_R = 0, K_LDUR = 1, K_STUR = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] op;
  logic        zero;
  logic        memReady;
  logic        memRead, memWrite, iord, irWe, pcWe, regWe, pcsrc, memToReg, reg2loc, illegal;
  logic [1:0]  alusrca, alusrcb;
  logic [3:0]  alucontrol, state;

  logic       sMemRead, sMemWrite, sIord, sIrWe, sPcWe, sRegWe, sPcsrc, sMemToReg, sReg2loc, sIllegal;
  logic [1:0] sAlusrca, sAlusrcb;
  logic [3:0] sAlu, sState;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.OPW(11)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_op(op), .i_zero(zero), .i_mem_ready(memReady),
    .o_mem_read(memRead), .o_mem_write(memWrite), .o_iord(iord), .o_ir_we(irWe),
    .o_pc_we(pcWe), .o_reg_we(regWe), .o_alusrca(alusrca), .o_alusrcb(alusrcb),
    .o_alucontrol(alucontrol), .o_pcsrc(pcsrc), .o_mem_to_reg(memToReg),
    .o_reg2loc(reg2loc), .o_illegal(illegal), .o_state(state)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, snapshot the outputs mid-cycle, then advance past the edge.
  task automatic runCycle(input logic rdy, input logic [10:0] opv, input logic zv);
    memReady = rdy; op = opv; zero = zv;
    #1;
    sState = state; sMemRead = memRead; sMemWrite = memWrite; sIord = iord;
    sIrWe = irWe; sPcWe = pcWe; sRegWe = regWe; sPcsrc = pcsrc; sMemToReg = memToReg;
    sReg2loc = reg2loc; sIllegal = illegal; sAlusrca = alusrca; sAlusrcb = alusrcb; sAlu = alucontrol;
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0; memReady = 1'b0; #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic int classify(input logic [10:0] o);
    if (o == OP_LDUR) return K_LDUR;
    if (o == OP_STUR) return K_STUR;
    if (o == OP_ADD || o == OP_SUB || o == OP_AND || o == OP_ORR) return K_R;
    if (o[10:3] == 8'b10110100) return K_CBZ;
    if (o[10:5] == 6'b000101) return K_B;
    return K_ILL;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; memReady = 1'b1; op = OP_ADD; zero = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks += 5;
      if (state !== S_FETCH) begin errors++; $display("[TB] FAIL reset_state cyc %0d: got %0d want %0d", i, state, S_FETCH); end
      if (memRead !== 1'b1) begin errors++; $display("[TB] FAIL reset_memread cyc %0d: got %b want 1", i, memRead); end
      if (pcWe !== 1'b0) begin errors++; $display("[TB] FAIL reset_pcwe cyc %0d: got %b want 0", i, pcWe); end
      if (irWe !== 1'b0) begin errors++; $display("[TB] FAIL reset_irwe cyc %0d: got %b want 0", i, irWe); end
      if (regWe !== 1'b0) begin errors++; $display("[TB] FAIL reset_regwe cyc %0d: got %b want 0", i, regWe); end
      @(posedge clk);
    end
    #1;
    checks += 3;
    if (memWrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_memwrite: got %b want 0", memWrite); end
    if (alusrcb !== 2'b01) begin errors++; $display("[TB] FAIL reset_alusrcb: got %b want 01", alusrcb); end
    if (alucontrol !== 4'b0010) begin errors++; $display("[TB] FAIL reset_alu: got %b want 0010", alucontrol); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (state !== S_DECODE) begin errors++; $display("[TB] FAIL reset_release: got %0d want %0d", state, S_DECODE); end
  endtask

  task automatic test_rtype(input logic [10:0] opv, input logic [3:0] expAlu);
    logic [3:0] expSeq [4];
    expSeq = '{S_FETCH, S_DECODE, S_REX, S_RWB};
    doReset();
    for (int c = 0; c < 4; c++) begin
      runCycle(1'b1, (c == 0) ? 11'h7FF : opv, 1'b0);
      checks += 2;
      if (sState !== expSeq[c]) begin errors++; $display("[TB] FAIL rtype_state op %b cyc %0d: got %0d want %0d", opv, c, sState, expSeq[c]); end
      if (sRegWe !== (c == 3)) begin errors++; $display("[TB] FAIL rtype_regwe op %b cyc %0d: got %b want %b", opv, c, sRegWe, (c == 3)); end
      if (c == 2) begin
        checks += 2;
        if (sAlu !== expAlu) begin errors++; $display("[TB] FAIL rtype_alu op %b: got %b want %b", opv, sAlu, expAlu); end
        if (sAlusrca !== 2'b10) begin errors++; $display("[TB] FAIL rtype_srca op %b: got %b want 10", opv, sAlusrca); end
      end
    end
    checks++;
    if (state !== S_FETCH) begin errors++; $display("[TB] FAIL rtype_end op %b: got %0d want %0d", opv, state, S_FETCH); end
  endtask

  task automatic test_ldur_wait();
    int regWrites = 0;
    doReset();
    for (int c = 0; c < 8; c++) begin
      runCycle(!(c >= 3 && c <= 5), (c == 0) ? 11'h155 : OP_LDUR, 1'b0);
      if (sRegWe && sMemToReg) regWrites++;
      if (c >= 3 && c <= 6) begin
        checks++;
        if (!(sState === S_MEMRD && sMemRead === 1'b1 && sIord === 1'b1))
          begin errors++; $display("[TB] FAIL ldur_wait cyc %0d: state %0d rd %b iord %b want %0d 1 1", c, sState, sMemRead, sIord, S_MEMRD); end
      end
      if (c == 7) begin
        checks++;
        if (sState !== S_MEMWB) begin errors++; $display("[TB] FAIL ldur_wb: got %0d want %0d", sState, S_MEMWB); end
      end
    end
    checks += 2;
    if (regWrites != 1) begin errors++; $display("[TB] FAIL ldur_regwe_count: got %0d want 1", regWrites); end
    if (state !== S_FETCH) begin errors++; $display("[TB] FAIL ldur_end: got %0d want %0d", state, S_FETCH); end
  endtask

  task automatic test_stur();
    int regWrites = 0;
    doReset();
    for (int c = 0; c < 4; c++) begin
      runCycle(1'b1, (c == 0) ? 11'h2AA : OP_STUR, 1'b0);
      regWrites += int'(sRegWe);
      if (c == 1 || c == 2) begin
        checks++;
        if (sReg2loc !== 1'b1) begin errors++; $display("[TB] FAIL stur_reg2loc cyc %0d: got %b want 1", c, sReg2loc); end
      end
      if (c == 3) begin
        checks++;
        if ({sState, sMemWrite, sMemRead, sIord, sReg2loc} !== {S_MEMWR, 4'b1011})
          begin errors++; $display("[TB] FAIL stur_memwr: state %0d wr %b rd %b iord %b r2l %b want %0d 1 0 1 1", sState, sMemWrite, sMemRead, sIord, sReg2loc, S_MEMWR); end
      end
    end
    checks += 2;
    if (regWrites != 0) begin errors++; $display("[TB] FAIL stur_regwe: got %0d want 0", regWrites); end
    if (state !== S_FETCH) begin errors++; $display("[TB] FAIL stur_end: got %0d want %0d", state, S_FETCH); end
  endtask

  task automatic test_branch(input logic [10:0] opv, input logic zv, input logic [3:0] expState,
                             input logic expPcWe, input logic expIll);
    int illCount = 0;
    doReset();
    for (int c = 0; c < 3; c++) begin
      runCycle(1'b1, (c == 0) ? 11'h0F0 : opv, zv);
      illCount += int'(sIllegal);
      if (c == 2) begin
        checks += 2;
        if (sState !== expState) begin errors++; $display("[TB] FAIL branch_state op %b: got %0d want %0d", opv, sState, expState); end
        if (sPcWe !== expPcWe) begin errors++; $display("[TB] FAIL branch_pcwe op %b z %b: got %b want %b", opv, zv, sPcWe, expPcWe); end
        if (expState != S_ILL) begin
          checks++;
          if (sPcsrc !== 1'b1) begin errors++; $display("[TB] FAIL branch_pcsrc op %b: got %b want 1", opv, sPcsrc); end
        end
        if (expState == S_CBZ) begin
          checks++;
          if (sAlu !== 4'b0111) begin errors++; $display("[TB] FAIL cbz_alu: got %b want 0111", sAlu); end
        end
      end
    end
    checks += 2;
    if (illCount != int'(expIll)) begin errors++; $display("[TB] FAIL branch_illegal op %b: got %0d want %0d", opv, illCount, expIll); end
    if (state !== S_FETCH) begin errors++; $display("[TB] FAIL branch_end op %b: got %0d want %0d", opv, state, S_FETCH); end
  endtask

  task automatic test_reset_midwait();
    int regWrites = 0;
    doReset();
    runCycle(1'b1, 11'h3C3, 1'b0);
    runCycle(1'b1, OP_LDUR, 1'b0);
    runCycle(1'b1, OP_LDUR, 1'b0);
    runCycle(1'b0, OP_LDUR, 1'b0);
    checks++;
    if (sState !== S_MEMRD) begin errors++; $display("[TB] FAIL midwait_pre: got %0d want %0d", sState, S_MEMRD); end
    memReady = 1'b1; rst_n = 1'b0;
    #1;
    checks += 3;
    if (state !== S_FETCH) begin errors++; $display("[TB] FAIL midwait_async: got %0d want %0d", state, S_FETCH); end
    if (regWe !== 1'b0) begin errors++; $display("[TB] FAIL midwait_regwe: got %b want 0", regWe); end
    if (pcWe !== 1'b0 || irWe !== 1'b0) begin errors++; $display("[TB] FAIL midwait_we: pc %b ir %b want 0 0", pcWe, irWe); end
    @(posedge clk); #1;
    checks++;
    if (regWe !== 1'b0 || state !== S_FETCH) begin errors++; $display("[TB] FAIL midwait_hold: regwe %b state %0d want 0 %0d", regWe, state, S_FETCH); end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      runCycle(1'b1, (c == 0) ? 11'h001 : OP_LDUR, 1'b0);
      regWrites += int'(sRegWe);
    end
    checks += 2;
    if (regWrites != 1) begin errors++; $display("[TB] FAIL midwait_ldur_regwe: got %0d want 1", regWrites); end
    if (state !== S_FETCH) begin errors++; $display("[TB] FAIL midwait_ldur_end: got %0d want %0d", state, S_FETCH); end
  endtask

  // Random stream: each instruction's length, strobe cycles and enable pulses follow from its class and wait counts.
  task automatic test_random(input int nInstr);
    doReset();
    for (int n = 0; n < nInstr; n++) begin
      int kindSel, k, fw, mw, total, base, memStart;
      int cPc, cReg, cIr, cIll, cWr, cRd, cFetch, both;
      int ePc, eReg, eIll, eWr, eRd;
      logic [10:0] opv;
      logic zv, rdy;
      kindSel = $urandom_range(0, 8);
      case (kindSel)
        0: opv = OP_LDUR;
        1: opv = OP_STUR;
        2: opv = OP_ADD;
        3: opv = OP_SUB;
        4: opv = OP_AND;
        5: opv = OP_ORR;
        6: opv = {8'b10110100, 3'($urandom)};
        7: opv = {6'b000101, 5'($urandom)};
        default: begin
          opv = 11'b0;
          for (int t = 0; t < 20; t++) begin
            opv = 11'($urandom);
            if (classify(opv) == K_ILL) break;
            opv = 11'b0;
          end
        end
      endcase
      k  = classify(opv);
      zv = 1'($urandom);
      fw = $urandom_range(0, 2);
      mw = (k == K_LDUR || k == K_STUR) ? $urandom_range(0, 3) : 0;
      base = (k == K_LDUR) ? 5 : (k == K_R || k == K_STUR) ? 4 : 3;
      total = base + fw + mw;
      memStart = fw + 3;
      cPc = 0; cReg = 0; cIr = 0; cIll = 0; cWr = 0; cRd = 0; cFetch = 0; both = 0;
      for (int c = 0; c < total; c++) begin
        if (c <= fw) rdy = (c == fw);
        else if (mw >= 0 && (k == K_LDUR || k == K_STUR) && c >= memStart && c <= memStart + mw) rdy = (c == memStart + mw);
        else rdy = 1'($urandom);
        runCycle(rdy, (c <= fw) ? 11'($urandom) : opv, zv);
        cPc += int'(sPcWe); cReg += int'(sRegWe); cIr += int'(sIrWe); cIll += int'(sIllegal);
        cWr += int'(sMemWrite); cRd += int'(sMemRead); cFetch += int'(sState == S_FETCH);
        both += int'(sMemRead & sMemWrite);
      end
      ePc  = 1 + int'(k == K_B) + int'(k == K_CBZ && zv);
      eReg = int'(k == K_R || k == K_LDUR);
      eIll = int'(k == K_ILL);
      eWr  = (k == K_STUR) ? mw + 1 : 0;
      eRd  = fw + 1 + ((k == K_LDUR) ? mw + 1 : 0);
      checks += 9;
      if (state !== S_FETCH) begin errors++; $display("[TB] FAIL rand_end #%0d op %b: got %0d want %0d", n, opv, state, S_FETCH); end
      if (cPc != ePc) begin errors++; $display("[TB] FAIL rand_pcwe #%0d op %b: got %0d want %0d", n, opv, cPc, ePc); end
      if (cReg != eReg) begin errors++; $display("[TB] FAIL rand_regwe #%0d op %b: got %0d want %0d", n, opv, cReg, eReg); end
      if (cIr != 1) begin errors++; $display("[TB] FAIL rand_irwe #%0d op %b: got %0d want 1", n, opv, cIr); end
      if (cIll != eIll) begin errors++; $display("[TB] FAIL rand_illegal #%0d op %b: got %0d want %0d", n, opv, cIll, eIll); end
      if (cWr != eWr) begin errors++; $display("[TB] FAIL rand_memwr #%0d op %b: got %0d want %0d", n, opv, cWr, eWr); end
      if (cRd != eRd) begin errors++; $display("[TB] FAIL rand_memrd #%0d op %b: got %0d want %0d", n, opv, cRd, eRd); end
      if (cFetch != fw + 1) begin errors++; $display("[TB] FAIL rand_fetch #%0d op %b: got %0d want %0d", n, opv, cFetch, fw + 1); end
      if (both != 0) begin errors++; $display("[TB] FAIL rand_rdwr_both #%0d op %b: got %0d want 0", n, opv, both); end
    end
  endtask

  initial begin
    rst_n = 1'b0; op = '0; zero = 1'b0; memReady = 1'b0;
    test_reset();
    test_rtype(OP_ADD, 4'b0010);
    test_rtype(OP_SUB, 4'b0110);
    test_rtype(OP_AND, 4'b0000);
    test_rtype(OP_ORR, 4'b0001);
    test_ldur_wait();
    test_stur();
    test_branch(OP_CBZ, 1'b1, S_CBZ, 1'b1, 1'b0);
    test_branch(OP_CBZ, 1'b0, S_CBZ, 1'b0, 1'b0);
    test_branch(OP_B, 1'b0, S_BR, 1'b1, 1'b0);
    test_branch(11'b00000000000, 1'b0, S_ILL, 1'b0, 1'b1);
    test_reset_midwait();
    test_random(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
